// File: rtl/text_vram_pixclk.sv
// text_vram_pixclk: character-cell video RAM for the text console with clear sweep and VGA pixel-clock divider.
// Ports:
//   clk, rst (sync, active-low)
//   wr_row/wr_col/wr_data/wren : writer port, ignored when out of range or busy
//   rd_row/rd_col -> rd_data   : registered read, 1-cycle latency, 0x00 when out of range or busy
//   waddr/raddr                : combinational linear cell addresses (row*COLS+col, 12 bits)
//   clear -> busy              : blank the whole screen; busy high while sweeping
//   pclk                       : system clock divided to the pixel clock
module text_vram_pixclk #(
    parameter int COLS    = 70,
    parameter int ROWS    = 30,
    parameter int DEPTH   = 4096,
    parameter int CLK_HZ  = 50000000,
    parameter int PCLK_HZ = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] wr_row,
    input  logic [7:0] wr_col,
    input  logic [7:0] wr_data,
    input  logic       wren,
    input  logic [5:0] rd_row,
    input  logic [7:0] rd_col,
    output logic [7:0] rd_data,
    output logic [11:0] waddr,
    output logic [11:0] raddr,
    input  logic       clear,
    output logic       busy,
    output logic       pclk
);
    localparam int HALF = CLK_HZ / (2 * PCLK_HZ);
    localparam logic [11:0] LAST = 12'(ROWS * COLS - 1);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]  state;
    logic [11:0] ptr;
    logic [31:0] cnt;
    logic [7:0]  mem [DEPTH];
    logic        w_in, r_in, mem_we;
    logic [11:0] mem_a;
    logic [7:0]  mem_d;

    assign waddr = 12'(32'(wr_row) * COLS + 32'(wr_col));
    assign raddr = 12'(32'(rd_row) * COLS + 32'(rd_col));
    assign w_in  = 32'(wr_row) < ROWS && 32'(wr_col) < COLS;
    assign r_in  = 32'(rd_row) < ROWS && 32'(rd_col) < COLS;
    assign busy  = state == CLEAR;

    // The sweep owns the single write port; external writes are locked out while busy.
    assign mem_we = rst && (busy || (wren && w_in));
    assign mem_a  = busy ? ptr : waddr;
    assign mem_d  = busy ? 8'h00 : wr_data;

    always_ff @(posedge clk)
        if (mem_we) mem[mem_a] <= mem_d;

    // Read-before-write: a same-address write lands after this sample.
    always_ff @(posedge clk)
        rd_data <= (!rst || busy || !r_in) ? 8'h00 : mem[raddr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else if (clear) begin
            state <= CLEAR;
            ptr   <= '0;
        end else if (busy) begin
            state <= (ptr == LAST) ? IDLE : CLEAR;
            ptr   <= (ptr == LAST) ? 12'd0 : ptr + 12'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            pclk <= 1'b0;
        end else if (cnt == 32'(HALF - 1)) begin
            cnt  <= '0;
            pclk <= ~pclk;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_text_vram_pixclk.sv
// tb_text_vram_pixclk: randomized self-checking bench for text_vram_pixclk against a cell-array model.
module tb_text_vram_pixclk;
    localparam int ROWS = 30;
    localparam int COLS = 70;
    localparam int SWEEP = ROWS * COLS;

    logic       clk = 1'b0, rst = 1'b0;
    logic [5:0] wr_row = '0, rd_row = '0;
    logic [7:0] wr_col = '0, rd_col = '0, wr_data = '0;
    logic       wren = 1'b0, clear = 1'b0;
    logic [7:0] rd_data, rd_data4;
    logic [11:0] waddr, raddr, waddr4, raddr4;
    logic       busy, busy4, pclk, pclk4;

    int n_cmp = 0, n_err = 0;
    logic [7:0] model [ROWS][COLS];
    int busy_left = SWEEP, edges = 0;
    logic [7:0] exp_rd = '0;

    always #5 clk = ~clk;

    text_vram_pixclk u_dut (
        .clk(clk), .rst(rst), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .wren(wren), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .waddr(waddr), .raddr(raddr), .clear(clear), .busy(busy), .pclk(pclk)
    );

    text_vram_pixclk #(.PCLK_HZ(12500000)) u_div4 (
        .clk(clk), .rst(rst), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .wren(wren), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data4),
        .waddr(waddr4), .raddr(raddr4), .clear(clear), .busy(busy4), .pclk(pclk4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic zero_model;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) model[r][c] = 8'h00;
    endtask

    // One clock edge: advance the model from the inputs in force, then check outputs.
    task automatic tick;
        @(posedge clk);
        if (!rst) begin
            exp_rd = 8'h00;
            busy_left = SWEEP;
            edges = 0;
            zero_model();
        end else begin
            edges++;
            if (busy_left > 0 || int'(rd_row) >= ROWS || int'(rd_col) >= COLS) exp_rd = 8'h00;
            else exp_rd = model[rd_row][rd_col];
            if (busy_left == 0 && wren && int'(wr_row) < ROWS && int'(wr_col) < COLS)
                model[wr_row][wr_col] = wr_data;
            if (clear) begin
                busy_left = SWEEP;
                zero_model();
            end else if (busy_left > 0) busy_left--;
        end
        @(negedge clk);
        chk("rd_data", 32'(rd_data), 32'(exp_rd));
        chk("busy", 32'(busy), 32'(busy_left > 0));
        chk("pclk", 32'(pclk), 32'(edges % 2));
        chk("rd_data4", 32'(rd_data4), 32'(exp_rd));
        chk("busy4", 32'(busy4), 32'(busy_left > 0));
        chk("pclk4", 32'(pclk4), 32'((edges / 2) % 2));
    endtask

    task automatic drive(input int wrow, input int wcol, input int wd, input bit we,
                         input int rrow, input int rcol, input bit clr);
        wr_row = 6'(wrow); wr_col = 8'(wcol); wr_data = 8'(wd); wren = we;
        rd_row = 6'(rrow); rd_col = 8'(rcol); clear = clr;
        #1;
        chk("waddr", 32'(waddr), (wrow * COLS + wcol) % 4096);
        chk("raddr", 32'(raddr), (rrow * COLS + rcol) % 4096);
        tick();
    endtask

    function automatic int rnd_row();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 35)) : int'($urandom_range(0, 3));
    endfunction

    function automatic int rnd_col();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 75)) : int'($urandom_range(0, 7));
    endfunction

    task automatic rnd_cycle(input bit allow_clear);
        drive(rnd_row(), rnd_col(), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
              rnd_row(), rnd_col(), allow_clear && $urandom_range(0, 699) == 0);
    endtask

    task automatic wait_sweep(input string tag, input bit rnd_writes);
        int k = 0;
        while (busy === 1'b1 && k < 3000) begin
            if (rnd_writes) drive(rnd_row(), rnd_col(), 8'h77, 1'b1, rnd_row(), rnd_col(), 1'b0);
            else drive(0, 0, 0, 1'b0, ROWS - 1, COLS - 1, 1'b0);
            k++;
        end
        chk(tag, k, SWEEP);
    endtask

    initial begin
        zero_model();
        repeat (3) drive(0, 0, 0, 1'b0, 0, 0, 1'b0);
        chk("reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        wait_sweep("busy_len_reset", 1'b0);
        drive(0, 0, 0, 1'b0, ROWS - 1, COLS - 1, 1'b0);
        chk("rd_29_69", 32'(rd_data), 32'h00);

        drive(2, 5, 8'h41, 1'b1, 0, 0, 1'b0);
        drive(0, 0, 0, 1'b0, 2, 5, 1'b0);
        chk("rd_2_5", 32'(rd_data), 32'h41);

        drive(0, 0, 8'h41, 1'b1, 0, 0, 1'b0);
        drive(0, COLS, 8'h5A, 1'b1, 1, 0, 1'b0);
        drive(ROWS, 0, 8'h5A, 1'b1, 0, COLS, 1'b0);
        drive(0, 0, 0, 1'b0, 1, 0, 1'b0);
        chk("rd_alias_1_0", 32'(rd_data), 32'h00);
        drive(0, 0, 0, 1'b0, ROWS, 0, 1'b0);
        chk("rd_oor", 32'(rd_data), 32'h00);

        drive(0, 0, 8'h42, 1'b1, 0, 0, 1'b0);
        chk("rdw_old", 32'(rd_data), 32'h41);
        drive(0, 0, 0, 1'b0, 0, 0, 1'b0);
        chk("rdw_new", 32'(rd_data), 32'h42);

        repeat (1500) rnd_cycle(1'b1);
        if (busy === 1'b1) wait_sweep("busy_len_rnd", 1'b1);

        for (int i = 0; i < 8; i++) drive(i % 4, i, 8'h60 + i, 1'b1, 0, 0, 1'b0);
        drive(0, 0, 0, 1'b0, 3, 7, 1'b1);
        chk("pre_clear_rd", 32'(rd_data), 32'h67);
        wait_sweep("busy_len_clear", 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 1'b0, i % 4, i, 1'b0);
            drive(0, 0, 0, 1'b0, i % 4, i, 1'b0);
            chk("post_clear_rd", 32'(rd_data), 32'h00);
        end

        drive(1, 1, 8'h33, 1'b1, 0, 0, 1'b1);
        repeat (500) drive(1, 1, 8'h34, 1'b1, 1, 1, 1'b0);
        drive(0, 0, 0, 1'b0, 0, 0, 1'b1);
        wait_sweep("busy_len_restart", 1'b1);

        repeat (300) rnd_cycle(1'b0);
        drive(2, 2, 8'h21, 1'b1, 0, 0, 1'b1);
        repeat (100) rnd_cycle(1'b0);
        rst = 1'b0;
        repeat (2) drive(0, 0, 8'h99, 1'b1, 0, 0, 1'b0);
        rst = 1'b1;
        wait_sweep("busy_len_rst_mid", 1'b1);
        repeat (1000) rnd_cycle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
